// File: rtl/tex_env_cascade_if.sv
`default_nettype none
// ============================================================================
// Module   : tex_env_cascade_if
// Brief    : Fragment stream bundle (texel-filter side in, fragment side out).
// Revision : 1.0 - initial release
// ============================================================================
interface tex_env_cascade_if #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int NUM_STAGES      = 2,
    parameter int TAG_WIDTH       = 16
);
    localparam int PIXEL_WIDTH = NUM_CHANNELS * SUB_PIXEL_WIDTH;

    logic                              s_valid;
    logic                              s_ready;
    logic [PIXEL_WIDTH-1:0]            s_primary;
    logic [NUM_STAGES*PIXEL_WIDTH-1:0] s_texels;
    logic [TAG_WIDTH-1:0]              s_tag;

    logic                              m_valid;
    logic                              m_ready;
    logic [PIXEL_WIDTH-1:0]            m_color;
    logic [TAG_WIDTH-1:0]              m_tag;

    modport slave (
        input  s_valid, s_primary, s_texels, s_tag, m_ready,
        output s_ready, m_valid, m_color, m_tag
    );

    modport master (
        output s_valid, s_primary, s_texels, s_tag, m_ready,
        input  s_ready, m_valid, m_color, m_tag
    );
endinterface
`default_nettype wire

// File: rtl/tex_env_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tex_env_cascade
// Brief    : Cascaded texture-environment combine stages with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module tex_env_cascade #(
    parameter  int SUB_PIXEL_WIDTH = 8,
    parameter  int NUM_CHANNELS    = 4,
    parameter  int NUM_STAGES      = 2,
    parameter  int TAG_WIDTH       = 16,
    localparam int PIXEL_WIDTH     = NUM_CHANNELS * SUB_PIXEL_WIDTH
) (
    input  wire logic                              aclk,
    input  wire logic                              reset,
    input  wire logic [3*NUM_STAGES-1:0]           conf_mode,
    input  wire logic [NUM_STAGES-1:0]             conf_enable,
    input  wire logic [NUM_STAGES*PIXEL_WIDTH-1:0] conf_env_color,
    tex_env_cascade_if.slave                       stream,
    output logic                                   idle
);

    localparam logic [SUB_PIXEL_WIDTH-1:0] c_max           = '1;
    localparam logic [2:0]                 c_mode_replace  = 3'd0;
    localparam logic [2:0]                 c_mode_modulate = 3'd1;
    localparam logic [2:0]                 c_mode_add      = 3'd2;
    localparam logic [2:0]                 c_mode_decal    = 3'd3;
    localparam logic [2:0]                 c_mode_blend    = 3'd4;

    // (a*b + MAX) >> W keeps mul(MAX,MAX) = MAX and mul(0,x) = 0
    function automatic logic [SUB_PIXEL_WIDTH-1:0] f_mul(
        input logic [SUB_PIXEL_WIDTH-1:0] a,
        input logic [SUB_PIXEL_WIDTH-1:0] b
    );
        return SUB_PIXEL_WIDTH'((({{SUB_PIXEL_WIDTH{1'b0}}, a} * {{SUB_PIXEL_WIDTH{1'b0}}, b})
                                 + {{SUB_PIXEL_WIDTH{1'b0}}, c_max}) >> SUB_PIXEL_WIDTH);
    endfunction

    function automatic logic [SUB_PIXEL_WIDTH-1:0] f_sat_add(
        input logic [SUB_PIXEL_WIDTH-1:0] a,
        input logic [SUB_PIXEL_WIDTH-1:0] b
    );
        logic [SUB_PIXEL_WIDTH:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[SUB_PIXEL_WIDTH] ? c_max : w_sum[SUB_PIXEL_WIDTH-1:0];
    endfunction

    function automatic logic [SUB_PIXEL_WIDTH-1:0] f_combine(
        input logic [2:0]                 mode,
        input logic [SUB_PIXEL_WIDTH-1:0] p,
        input logic [SUB_PIXEL_WIDTH-1:0] t,
        input logic [SUB_PIXEL_WIDTH-1:0] e,
        input logic [SUB_PIXEL_WIDTH-1:0] ta,
        input logic                       is_alpha
    );
        logic [SUB_PIXEL_WIDTH-1:0] w_res;
        w_res = p;
        case (mode)
            c_mode_replace:  w_res = t;
            c_mode_modulate: w_res = f_mul(p, t);
            c_mode_add:      w_res = f_sat_add(p, t);
            c_mode_decal:    w_res = is_alpha ? p
                                     : f_sat_add(f_mul(p, c_max - ta), f_mul(t, ta));
            c_mode_blend:    w_res = is_alpha ? f_mul(p, t)
                                     : f_sat_add(f_mul(p, c_max - t), f_mul(e, t));
            default:         w_res = p;
        endcase
        return w_res;
    endfunction

    // Index i of the w_src_* arrays is what feeds stage i; index NUM_STAGES is the output
    logic                              w_src_valid [NUM_STAGES+1];
    logic [PIXEL_WIDTH-1:0]            w_src_color [NUM_STAGES+1];
    logic [TAG_WIDTH-1:0]              w_src_tag   [NUM_STAGES+1];
    logic [NUM_STAGES*PIXEL_WIDTH-1:0] w_src_tex   [NUM_STAGES];
    logic                              w_ready     [NUM_STAGES];
    logic [NUM_STAGES-1:0]             w_valid_vec;

    assign w_src_valid[0] = stream.s_valid;
    assign w_src_color[0] = stream.s_primary;
    assign w_src_tag[0]   = stream.s_tag;
    assign w_src_tex[0]   = stream.s_texels;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        localparam logic [NUM_STAGES-1:0] c_low_mask = (NUM_STAGES)'((1 << i) - 1);

        logic                   r_valid;
        logic [PIXEL_WIDTH-1:0] r_color;
        logic [TAG_WIDTH-1:0]   r_tag;
        logic [PIXEL_WIDTH-1:0] w_texel;
        logic [PIXEL_WIDTH-1:0] w_env;
        logic [PIXEL_WIDTH-1:0] w_comb;
        logic [PIXEL_WIDTH-1:0] w_next_color;

        assign w_texel = w_src_tex[i][PIXEL_WIDTH-1:0];
        assign w_env   = conf_env_color[i*PIXEL_WIDTH +: PIXEL_WIDTH];

        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
            localparam logic c_is_alpha = (NUM_CHANNELS > 1) && (c == NUM_CHANNELS - 1);
            assign w_comb[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH] = f_combine(
                conf_mode[3*i +: 3],
                w_src_color[i][c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                w_texel[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                w_env[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                w_texel[(NUM_CHANNELS-1)*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                c_is_alpha);
        end

        assign w_next_color = conf_enable[i] ? w_comb : w_src_color[i];

        // Unrolled form of !valid_i || ready_{i+1}: ready unless every stage from i down is full
        assign w_ready[i] = stream.m_ready || !(&(w_valid_vec | c_low_mask));

        always_ff @(posedge aclk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_color <= '0;
                r_tag   <= '0;
            end else if (w_ready[i]) begin
                r_valid <= w_src_valid[i];
                if (w_src_valid[i]) begin
                    r_color <= w_next_color;
                    r_tag   <= w_src_tag[i];
                end
            end
        end

        if (i < NUM_STAGES - 1) begin : g_tex
            logic [(NUM_STAGES-1-i)*PIXEL_WIDTH-1:0] r_tex;

            always_ff @(posedge aclk) begin
                if (reset) begin
                    r_tex <= '0;
                end else if (w_ready[i] && w_src_valid[i]) begin
                    r_tex <= w_src_tex[i][PIXEL_WIDTH +: (NUM_STAGES-1-i)*PIXEL_WIDTH];
                end
            end

            assign w_src_tex[i+1] = (NUM_STAGES*PIXEL_WIDTH)'(r_tex);
        end

        assign w_src_valid[i+1] = r_valid;
        assign w_src_color[i+1] = r_color;
        assign w_src_tag[i+1]   = r_tag;
        assign w_valid_vec[i]   = r_valid;
    end

    assign stream.s_ready = w_ready[0] && !reset;
    assign stream.m_valid = w_src_valid[NUM_STAGES];
    assign stream.m_color = w_src_color[NUM_STAGES];
    assign stream.m_tag   = w_src_tag[NUM_STAGES];
    assign idle           = ~|w_valid_vec;

endmodule
`default_nettype wire

// File: tb/tb_tex_env_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_tex_env_cascade
// Brief    : Scoreboarded random/directed bench for tex_env_cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tex_env_cascade;

    localparam int SPW  = 8;
    localparam int NC   = 4;
    localparam int NS   = 2;
    localparam int TW   = 16;
    localparam int PW   = NC * SPW;
    localparam int MAXV = (1 << SPW) - 1;

    logic                 aclk = 1'b0;
    logic                 reset = 1'b1;
    logic [3*NS-1:0]      conf_mode = '0;
    logic [NS-1:0]        conf_enable = '0;
    logic [NS*PW-1:0]     conf_env_color = '0;
    logic                 idle;

    tex_env_cascade_if #(.SUB_PIXEL_WIDTH(SPW), .NUM_CHANNELS(NC),
                         .NUM_STAGES(NS), .TAG_WIDTH(TW)) bus ();

    tex_env_cascade #(.SUB_PIXEL_WIDTH(SPW), .NUM_CHANNELS(NC),
                      .NUM_STAGES(NS), .TAG_WIDTH(TW)) dut (
        .aclk           (aclk),
        .reset          (reset),
        .conf_mode      (conf_mode),
        .conf_enable    (conf_enable),
        .conf_env_color (conf_env_color),
        .stream         (bus),
        .idle           (idle)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [PW-1:0] color;
        logic [TW-1:0] tag;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_mode = 0;   // 0 always ready, 1 random, 2 toggle, 3 stalled
    bit   pre_tag_watch = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic int mulm(input int a, input int b);
        return (a * b + MAXV) / (MAXV + 1);
    endfunction

    function automatic int satm(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    function automatic logic [PW-1:0] ref_pixel(input logic [PW-1:0] prim,
                                                input logic [NS*PW-1:0] tex,
                                                input logic [3*NS-1:0] mode,
                                                input logic [NS-1:0] en,
                                                input logic [NS*PW-1:0] env);
        int p [NC];
        int t, e, ta, r;
        bit is_a;
        logic [PW-1:0] res;
        for (int c = 0; c < NC; c++) p[c] = int'(prim[c*SPW +: SPW]);
        for (int s = 0; s < NS; s++) begin
            if (en[s]) begin
                ta = int'(tex[s*PW + (NC-1)*SPW +: SPW]);
                for (int c = 0; c < NC; c++) begin
                    t = int'(tex[s*PW + c*SPW +: SPW]);
                    e = int'(env[s*PW + c*SPW +: SPW]);
                    is_a = (NC > 1) && (c == NC - 1);
                    case (int'(mode[3*s +: 3]))
                        0: r = t;
                        1: r = mulm(p[c], t);
                        2: r = satm(p[c] + t);
                        3: r = is_a ? p[c] : satm(mulm(p[c], MAXV - ta) + mulm(t, ta));
                        4: r = is_a ? mulm(p[c], t) : satm(mulm(p[c], MAXV - t) + mulm(e, t));
                        default: r = p[c];
                    endcase
                    p[c] = r;
                end
            end
        end
        for (int c = 0; c < NC; c++) res[c*SPW +: SPW] = SPW'(p[c]);
        return res;
    endfunction

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = 1'($urandom_range(0, 1));
            2:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'b0;
        endcase
    end

    logic [PW-1:0] h_color;
    logic [TW-1:0] h_tag;
    bit            held = 0;

    always @(negedge aclk) begin
        if (reset) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(bus.m_valid), 64'd1);
                check("hold_color", 64'(bus.m_color), 64'(h_color));
                check("hold_tag", 64'(bus.m_tag), 64'(h_tag));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag %0h emitted, required no output", bus.m_tag);
                end else begin
                    e_pop = sb.pop_front();
                    check("color", 64'(bus.m_color), 64'(e_pop.color));
                    check("tag", 64'(bus.m_tag), 64'(e_pop.tag));
                    if (e_pop.lat) check("latency", 64'(cyc - e_pop.cyc), 64'(NS));
                end
                if (pre_tag_watch)
                    check("no_pre_reset_tag", 64'(bus.m_tag[TW-1:TW-4] == 4'hE), 64'd0);
            end
            held    = bus.m_valid && !bus.m_ready;
            h_color = bus.m_color;
            h_tag   = bus.m_tag;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] prim, input logic [NS*PW-1:0] tex,
                        input logic [PW-1:0] exp_c, input logic [TW-1:0] tag, input bit lat);
        int n = 0;
        bus.s_valid   = 1'b1;
        bus.s_primary = prim;
        bus.s_texels  = tex;
        bus.s_tag     = tag;
        forever begin
            @(negedge aclk);
            if (bus.s_ready) begin
                sb.push_back('{color: exp_c, tag: tag, cyc: cyc, lat: lat});
                break;
            end
            n++;
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tag %0h s_ready=%0b required 1", tag, bus.s_ready);
                break;
            end
        end
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [TW-1:0] tag, input bit lat);
        logic [PW-1:0]    prim;
        logic [NS*PW-1:0] tex;
        prim = PW'($urandom);
        for (int s = 0; s < NS; s++) tex[s*PW +: PW] = PW'($urandom);
        send(prim, tex, ref_pixel(prim, tex, conf_mode, conf_enable, conf_env_color), tag, lat);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !idle) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_idle", 64'(idle), 64'd1);
    endtask

    task automatic rand_conf();
        for (int s = 0; s < NS; s++) begin
            conf_mode[3*s +: 3]          = 3'($urandom_range(0, 7));
            conf_enable[s]               = ($urandom_range(0, 3) != 0);
            conf_env_color[s*PW +: PW]   = PW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] tag;
        bus.s_valid   = 1'b1;
        bus.s_primary = '0;
        bus.s_texels  = '0;
        bus.s_tag     = '0;
        bus.m_ready   = 1'b1;

        repeat (3) begin
            @(negedge aclk);
            check("rst_s_ready", 64'(bus.s_ready), 64'd0);
            check("rst_m_valid", 64'(bus.m_valid), 64'd0);
            check("rst_m_color", 64'(bus.m_color), 64'd0);
            check("rst_m_tag", 64'(bus.m_tag), 64'd0);
            check("rst_idle", 64'(idle), 64'd1);
        end
        tick();
        reset = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge aclk);
        check("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("post_rst_idle", 64'(idle), 64'd1);
        tick();

        // MODULATE then ADD
        conf_mode = {3'd2, 3'd1};
        conf_enable = 2'b11;
        conf_env_color = '0;
        send(32'hFF808080, {32'h20202020, 32'h80FF4000}, 32'hA0A04020, 16'h0001, 1);
        drain();

        // DECAL on stage 0 only
        conf_mode = {3'd0, 3'd3};
        conf_enable = 2'b01;
        send(32'h40102030, {32'($urandom), 32'h80FFFFFF}, 32'h40889098, 16'h0002, 1);
        drain();

        // BLEND with black env and white texel
        conf_mode = {3'd0, 3'd4};
        conf_enable = 2'b01;
        conf_env_color = '0;
        send(32'h40102030, {32'($urandom), 32'hFFFFFFFF}, 32'h40000000, 16'h0003, 1);
        drain();

        // Disabled stage 1 ignores its REPLACE texel
        conf_mode = {3'd0, 3'd1};
        conf_enable = 2'b01;
        send(32'hFF808080, {32'($urandom), 32'h80FF4000}, 32'h80802000, 16'h0004, 1);
        send(32'hFF808080, {32'($urandom), 32'h80FF4000}, 32'h80802000, 16'h0005, 1);
        drain();

        // Random configs under random backpressure and gaps
        tag = 16'h0100;
        for (int ph = 0; ph < 4; ph++) begin
            rand_conf();
            rdy_mode = 1;
            for (int k = 0; k < 25; k++) begin
                if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 2)) tick();
                send_rand(tag, 0);
                tag++;
            end
            drain();
        end

        // m_ready toggling every cycle with back-to-back input
        rand_conf();
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            send_rand(tag, 0);
            tag++;
        end
        drain();

        // Reset with a full, stalled pipe
        rdy_mode = 3;
        tick();
        tick();
        send_rand(16'hE000, 0);
        send_rand(16'hE001, 0);
        bus.s_valid = 1'b1;
        bus.s_tag   = 16'hE002;
        repeat (2) begin
            @(negedge aclk);
            check("full_s_ready", 64'(bus.s_ready), 64'd0);
            check("full_m_valid", 64'(bus.m_valid), 64'd1);
            check("full_idle", 64'(idle), 64'd0);
        end
        tick();
        reset = 1'b1;
        pre_tag_watch = 1;
        sb.delete();
        tick();
        repeat (2) begin
            @(negedge aclk);
            check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
            check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
            check("midrst_idle", 64'(idle), 64'd1);
        end
        tick();
        reset = 1'b0;
        bus.s_valid = 1'b0;
        rdy_mode = 0;
        tick();
        tick();
        send_rand(16'h0200, 1);
        send_rand(16'h0201, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tex_env_cascade.md
Name: tex_env_cascade

Overview:
- Parametrised successor to the single-stage texture environment path of the texture mapping unit.
- Cascades NUM_STAGES texture-combine stages, one per texture unit, over NUM_CHANNELS sub-pixel channels.
- Adds a valid/ready stream handshake with per-stage bubble collapsing, so it sits between the texel filter outputs and the fragment pipeline and can stall.
- Sidebands (fragment tag) travel in lockstep with the colour.

Parameters:
- SUB_PIXEL_WIDTH, 8, bits per channel; MAX = 2^SUB_PIXEL_WIDTH-1.
- NUM_CHANNELS, 4, channels per pixel; channel NUM_CHANNELS-1 is alpha.
- NUM_STAGES, 2, cascaded combine stages (1..8).
- TAG_WIDTH, 16, opaque sideband width.
- PIXEL_WIDTH (local), NUM_CHANNELS*SUB_PIXEL_WIDTH.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- conf_mode  in  3*NUM_STAGES  combine mode of stage i at bits [3i+:3].
- conf_enable  in  NUM_STAGES  stage i enable; 0 = pass previous colour through.
- conf_env_color  in  NUM_STAGES*PIXEL_WIDTH  per-stage constant colour.
- s_valid  in  1  input fragment valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_primary  in  PIXEL_WIDTH  primary colour, which is the previous colour for stage 0.
- s_texels  in  NUM_STAGES*PIXEL_WIDTH  filtered texel for each stage.
- s_tag  in  TAG_WIDTH  sideband.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_color  out  PIXEL_WIDTH  final fragment colour.
- m_tag  out  TAG_WIDTH  sideband of m_color.
- idle  out  1  high when no stage holds a valid fragment.

Behaviour:
- Pipeline structure:
  - One register slice per stage. Stage i holds valid_i, the colour, the unconsumed texels (i+1..N-1) and the tag.
  - Latency with no stall: NUM_STAGES cycles from input handshake to m_valid.
  - Throughput: 1 fragment per cycle.
- Handshake:
  - ready_i = !valid_i || ready_{i+1}, with ready_N = m_ready. s_ready = ready_0 (combinational).
  - Stage i loads from stage i-1 when ready_i. Its valid_i becomes the upstream valid, so bubbles collapse.
  - Once m_valid is asserted, m_color and m_tag hold stable until m_ready.
  - m_valid never depends on m_ready.
- Combine arithmetic, per channel c, with p = previous, t = texel, e = env:
  - mul(a,b) = (a*b + MAX) >> SUB_PIXEL_WIDTH, with a full-width intermediate. mul(MAX,MAX) = MAX; mul(0,x) = 0.
  - ta = texel alpha.
- Modes:
  - 0 REPLACE: out = t.
  - 1 MODULATE: out = mul(p,t).
  - 2 ADD: out = min(p+t, MAX), all channels.
  - 3 DECAL: colour = mul(p, MAX-ta) + mul(t, ta), saturated to MAX; alpha = p.
  - 4 BLEND: colour = mul(p, MAX-t) + mul(e, t), saturated; alpha = mul(p,t).
  - 5-7: reserved, out = p.
  - If NUM_CHANNELS == 1, the channel is treated as colour; DECAL/BLEND alpha rules do not apply, and ta is the channel itself.
- Stage output: stage i output is the combine result when conf_enable[i], else p unchanged.
- Configuration:
  - conf_* are read combinationally as each fragment enters a stage.
  - Changing conf_* is legal only while idle = 1. Results for in-flight fragments are undefined otherwise.
- Reset:
  - All valid_i = 0, m_valid = 0, m_color = 0, m_tag = 0, idle = 1.
  - s_ready = 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight fragments without emitting them.
  - s_ready is 0 while reset is high.
- Boundary cases:
  - Full pipe with m_ready = 0: s_ready = 0 and all stages hold.
  - m_ready toggling every cycle: no loss or duplication, and order is preserved.
  - Simultaneous output handshake and input accept on a full pipe: all stages shift, so 1 in and 1 out.
- Sizing: implementation is 150-300 lines, using a generate loop over stages and channels.

Test Plan:
- Reset and idle: hold reset 3 cycles with s_valid = 1 → s_ready = 0, m_valid = 0, m_color = 0, idle = 1; after release s_ready = 1.
- Basic modes (NUM_STAGES = 2, stage 0 MODULATE, stage 1 ADD): primary 0xFF808080, t0 0x80FF4000, t1 0x20202020, m_ready = 1 → m_color = 0xA0A04020, exactly 2 cycles after the input handshake.
- DECAL and BLEND (single stage, channel width 8):
  - DECAL with p = 0x40102030, t = 0x80FFFFFF (ta = 0x80): colour channels from mul(p,0x7F) + mul(t,0x80), alpha = 0x40.
  - BLEND with e = 0x00000000 and t = 0xFFFFFFFF → colour 0x000000, alpha = p alpha.
  - Results checked against a bit-exact model.
- Disabled stage: conf_enable = 2'b01, stage 1 mode REPLACE → output equals the stage 0 result, and t1 is ignored.
- Backpressure: stream 100 fragments with incrementing tags and random s_valid/m_ready (50%) → 100 outputs in tag order, values match the model, and no output changes while m_valid && !m_ready.
- Reset mid-stream: assert reset with the pipe full and m_ready = 0 → no output ever carries a pre-reset tag, and the first post-reset fragment emerges after NUM_STAGES cycles.
